// File: rtl/multicycle_datapath.sv
// Datapath for the 32-bit multicycle MIPS core.
// Steered entirely by the 15-bit control bus from the control unit.
module multicycle_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] control_bus,
    input  logic [31:0] mem_rdata,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic        zero,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we
);

    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic       alusrca;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] pcsrc;
    logic [1:0] alusrcb;
    logic [2:0] aluctl;

    assign iord     = control_bus[14];
    assign memwrite = control_bus[13];
    assign irwrite  = control_bus[12];
    assign pcen     = control_bus[11];
    assign alusrca  = control_bus[10];
    assign regwrite = control_bus[9];
    assign regdst   = control_bus[8];
    assign memtoreg = control_bus[7];
    assign pcsrc    = control_bus[6:5];
    assign alusrcb  = control_bus[4:3];
    assign aluctl   = control_bus[2:0];

    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] data;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] aluout;
    logic [31:0] rf [32];

    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] signimm;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [31:0] aluresult;
    logic [31:0] pcnext;

    assign ra1     = ir[25:21];
    assign ra2     = ir[20:16];
    assign wa      = regdst ? ir[15:11] : ir[20:16];
    assign wd      = memtoreg ? data : aluout;
    assign signimm = {{16{ir[15]}}, ir[15:0]};

    // $0 is hardwired; reads bypass the storage entirely
    assign rd1 = (ra1 == 5'd0) ? 32'd0 : rf[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : rf[ra2];

    assign srca = alusrca ? a : pc;

    always_comb begin
        srcb = b;
        case (alusrcb)
            2'b00:   srcb = b;
            2'b01:   srcb = 32'd4;
            2'b10:   srcb = signimm;
            default: srcb = {signimm[29:0], 2'b00};
        endcase
    end

    always_comb begin
        aluresult = 32'd0;
        case (aluctl)
            3'b010:  aluresult = srca + srcb;
            3'b110:  aluresult = srca - srcb;
            3'b000:  aluresult = srca & srcb;
            3'b001:  aluresult = srca | srcb;
            3'b111:  aluresult = {31'd0, $signed(srca) < $signed(srcb)};
            default: aluresult = 32'd0;
        endcase
    end

    always_comb begin
        pcnext = aluresult;
        case (pcsrc)
            2'b01:   pcnext = aluout;
            2'b10:   pcnext = {pc[31:28], ir[25:0], 2'b00};
            default: pcnext = aluresult;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= RESET_PC;
            ir     <= '0;
            data   <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
        end else begin
            if (irwrite) ir <= mem_rdata;
            if (pcen)    pc <= pcnext;
            data   <= mem_rdata;
            a      <= rd1;
            b      <= rd2;
            aluout <= aluresult;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (regwrite && wa != 5'd0) begin
            rf[wa] <= wd;
        end
    end

    assign op        = ir[31:26];
    assign func      = ir[5:0];
    assign zero      = (aluresult == 32'd0);
    assign mem_addr  = iord ? aluout : pc;
    assign mem_wdata = b;
    assign mem_we    = memwrite;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Scoreboarded bench for multicycle_datapath: directed instruction
// sequences plus random control/data traffic against a reference model.
module tb_multicycle_datapath;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [14:0] cb = '0;
    logic [31:0] rd = '0;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        zero;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;

    multicycle_datapath dut (
        .clk         (clk),
        .reset       (reset),
        .control_bus (cb),
        .mem_rdata   (rd),
        .op          (op),
        .func        (func),
        .zero        (zero),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [5:0]  op;
        logic [5:0]  func;
        logic        zero;
        logic        we;
    } exp_t;

    exp_t  q[$];
    string qn[$];
    int    total = 0;
    int    bad = 0;

    // Architectural reference state
    logic [31:0] m_pc, m_ir, m_data, m_a, m_b, m_alu;
    logic [31:0] m_rf [32];

    function automatic void m_reset();
        m_pc = 32'd0; m_ir = 32'd0; m_data = 32'd0;
        m_a = 32'd0; m_b = 32'd0; m_alu = 32'd0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    endfunction

    function automatic logic [31:0] sext(logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] alu_res(logic [14:0] c);
        logic [31:0] x, y;
        x = c[10] ? m_a : m_pc;
        case (c[4:3])
            2'd0: y = m_b;
            2'd1: y = 32'd4;
            2'd2: y = sext(m_ir[15:0]);
            default: y = sext(m_ir[15:0]) * 4;
        endcase
        case (c[2:0])
            3'b010: return x + y;
            3'b110: return x - y;
            3'b000: return x & y;
            3'b001: return x | y;
            3'b111: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void m_step(logic [14:0] c, logic [31:0] r);
        logic [31:0] res, npc, na, nb, wd;
        logic [4:0]  wa;
        res = alu_res(c);
        wa  = c[8] ? m_ir[15:11] : m_ir[20:16];
        wd  = c[7] ? m_data : m_alu;
        na  = m_rf[m_ir[25:21]];
        nb  = m_rf[m_ir[20:16]];
        if (c[6:5] == 2'b01) npc = m_alu;
        else if (c[6:5] == 2'b10) npc = {m_pc[31:28], m_ir[25:0], 2'b00};
        else npc = res;
        if (c[9] && wa != 5'd0) m_rf[wa] = wd;
        m_a = na; m_b = nb; m_data = r; m_alu = res;
        if (c[12]) m_ir = r;
        if (c[11]) m_pc = npc;
    endfunction

    function automatic logic [14:0] mk(bit iord, bit memw, bit irw, bit pcen,
        bit srca, bit regw, bit regdst, bit m2r, logic [1:0] pcs,
        logic [1:0] sb, logic [2:0] ac);
        return {iord, memw, irw, pcen, srca, regw, regdst, m2r, pcs, sb, ac};
    endfunction

    task automatic drive(bit rs, logic [14:0] c, logic [31:0] r);
        exp_t e;
        @(negedge clk);
        reset = rs; cb = c; rd = r;
        if (!rs) m_reset();
        e.mask  = 6'h3f;
        e.addr  = c[14] ? m_alu : m_pc;
        e.wdata = m_b;
        e.op    = m_ir[31:26];
        e.func  = m_ir[5:0];
        e.zero  = (alu_res(c) == 32'd0);
        e.we    = c[13];
        q.push_back(e);
        qn.push_back("model");
    endtask

    task automatic want(string n, logic [5:0] mask, logic [31:0] addr,
        logic [31:0] wdata, logic [5:0] o, logic [5:0] f, logic z, logic w);
        exp_t e;
        e.mask = mask; e.addr = addr; e.wdata = wdata;
        e.op = o; e.func = f; e.zero = z; e.we = w;
        q.push_back(e);
        qn.push_back(n);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) m_step(cb, rd);
    endtask

    logic [14:0] c_fetch, c_dec, c_exi, c_wb, c_idle;

    task automatic step(logic [14:0] c);
        drive(1'b1, c, 32'd0);
        tick();
    endtask

    task automatic fetch(logic [31:0] instr);
        drive(1'b1, c_fetch, instr);
        tick();
    endtask

    task automatic addi(logic [4:0] rt, logic [15:0] imm);
        fetch({6'h08, 5'd0, rt, imm});
        step(c_dec);
        step(c_exi);
        step(c_wb);
    endtask

    task automatic jmp(logic [25:0] t);
        fetch({6'h02, t});
        step(mk(0, 0, 0, 1, 0, 0, 0, 0, 2'b10, 2'b00, 3'b000));
    endtask

    // Monitor: drains every expectation queued for this cycle
    initial begin
        exp_t  e;
        string n;
        bit    ok;
        forever begin
            @(negedge clk);
            #2;
            while (q.size() > 0) begin
                e = q.pop_front();
                n = qn.pop_front();
                ok = 1'b1;
                if (e.mask[0] && mem_addr  !== e.addr)  ok = 1'b0;
                if (e.mask[1] && mem_wdata !== e.wdata) ok = 1'b0;
                if (e.mask[2] && op        !== e.op)    ok = 1'b0;
                if (e.mask[3] && func      !== e.func)  ok = 1'b0;
                if (e.mask[4] && zero      !== e.zero)  ok = 1'b0;
                if (e.mask[5] && mem_we    !== e.we)    ok = 1'b0;
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL %s t=%0t got addr=%h wd=%h op=%h fn=%h z=%b we=%b want addr=%h wd=%h op=%h fn=%h z=%b we=%b mask=%h",
                        n, $time, mem_addr, mem_wdata, op, func, zero, mem_we,
                        e.addr, e.wdata, e.op, e.func, e.zero, e.we, e.mask);
                end
            end
        end
    end

    initial begin
        logic [14:0] c;
        c_fetch = mk(0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b01, 3'b010);
        c_dec   = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 3'b010);
        c_exi   = mk(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b10, 3'b010);
        c_wb    = mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b000);
        c_idle  = 15'd0;
        m_reset();

        for (int i = 0; i < 3; i++) begin
            c = 15'($urandom);
            c[4:0] = 5'b00010;
            drive(1'b0, c, $urandom);
            want("reset", 6'h3f, 32'd0, 32'd0, 6'd0, 6'd0, 1'b1, c[13]);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, c_idle, 32'd0);
            want("release", 6'h3f, 32'd0, 32'd0, 6'd0, 6'd0, 1'b1, 1'b0);
            tick();
        end

        drive(1'b1, c_fetch, 32'h2008_0005);
        want("fetch_addr", 6'h01, 32'd0, 0, 0, 0, 0, 0);
        tick();
        drive(1'b1, c_dec, 32'd0);
        want("fetch_ir", 6'h0d, 32'd4, 0, 6'h08, 6'h05, 0, 0);
        tick();
        drive(1'b1, c_exi, 32'd0);
        want("addi_ex", 6'h10, 0, 0, 0, 0, 1'b0, 0);
        tick();
        step(c_wb);
        step(c_idle);
        drive(1'b1, c_idle, 32'd0);
        want("addi_rd", 6'h02, 0, 32'd5, 0, 0, 0, 0);
        tick();

        addi(5'd8, 16'd7);
        addi(5'd9, 16'd7);
        jmp(26'd1);
        fetch(32'h1109_0003);
        drive(1'b1, c_dec, 32'd0);
        want("beq_pc", 6'h01, 32'd8, 0, 0, 0, 0, 0);
        tick();
        drive(1'b1, mk(0, 0, 0, 1, 1, 0, 0, 0, 2'b01, 2'b00, 3'b110), 32'd0);
        want("beq_eq", 6'h10, 0, 0, 0, 0, 1'b1, 0);
        tick();
        drive(1'b1, c_idle, 32'd0);
        want("beq_tgt", 6'h01, 32'd20, 0, 0, 0, 0, 0);
        tick();

        addi(5'd9, 16'd6);
        jmp(26'd1);
        fetch(32'h1109_0003);
        step(c_dec);
        drive(1'b1, mk(0, 0, 0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 3'b110), 32'd0);
        want("beq_ne", 6'h10, 0, 0, 0, 0, 1'b0, 0);
        tick();
        drive(1'b1, c_idle, 32'd0);
        want("beq_hold", 6'h01, 32'd8, 0, 0, 0, 0, 0);
        tick();

        fetch(32'h8C0A_0040);
        step(c_dec);
        step(c_exi);
        drive(1'b1, mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000), 32'hDEAD_BEEF);
        want("lw_addr", 6'h01, 32'h40, 0, 0, 0, 0, 0);
        tick();
        step(mk(0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 3'b000));
        fetch(32'hAC0A_0040);
        step(c_dec);
        step(c_exi);
        drive(1'b1, mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000), 32'd0);
        want("sw", 6'h23, 32'h40, 32'hDEAD_BEEF, 0, 0, 0, 1'b1);
        tick();

        addi(5'd0, 16'h1234);
        step(c_idle);
        drive(1'b1, c_idle, 32'd0);
        want("r0_write", 6'h02, 0, 32'd0, 0, 0, 0, 0);
        tick();

        addi(5'd11, 16'hFFFF);
        addi(5'd12, 16'd1);
        fetch(32'h016C_502A);
        step(c_dec);
        drive(1'b1, mk(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b111), 32'd0);
        want("slt_z", 6'h10, 0, 0, 0, 0, 1'b0, 0);
        tick();
        step(mk(0, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000));
        drive(1'b1, c_idle, 32'd0);
        want("slt_res", 6'h01, 32'd1, 0, 0, 0, 0, 0);
        tick();

        fetch(32'h8C0D_0000);
        drive(1'b1, c_idle, 32'hA000_0000);
        tick();
        step(mk(0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 3'b000));
        fetch(32'h01A0_0000);
        step(c_dec);
        step(mk(0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b01, 3'b010));
        drive(1'b1, c_fetch, 32'h0800_0010);
        want("j_pc", 6'h01, 32'hA000_0004, 0, 0, 0, 0, 0);
        tick();
        step(mk(0, 0, 0, 1, 0, 0, 0, 0, 2'b10, 2'b00, 3'b000));
        drive(1'b1, c_idle, 32'd0);
        want("j_tgt", 6'h01, 32'hA000_0040, 0, 0, 0, 0, 0);
        tick();

        fetch(32'h2160_FFFD);
        step(c_dec);
        step(mk(0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b10, 3'b010));
        drive(1'b1, c_fetch, 32'd0);
        want("wrap_pc", 6'h01, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        tick();
        drive(1'b1, c_idle, 32'd0);
        want("wrap", 6'h01, 32'd0, 0, 0, 0, 0, 0);
        tick();

        drive(1'b1, mk(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 3'b011), 32'd0);
        want("alu_011", 6'h10, 0, 0, 0, 0, 1'b1, 0);
        tick();

        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 39) != 0, 15'($urandom), $urandom);
            tick();
        end

        @(negedge clk);
        #4;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
